mem_port_arbiter: RTL

//  Shares the single 256-bit off-chip data memory port between two cache requesters:

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_rr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   arb_state_e : transaction FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   PORT_I/D    : port indices (0 = instruction cache, 1 = data cache)
//   DEF_*       : default widths and timeout
//   cnt_width() : timeout counter width, never below 1 bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 256;
  localparam int DEF_TIMEOUT = 1024;

  // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr
// Combinational 2-way round-robin picker.
//   req_i[1:0]    in  : request per port
//   last_grant_i  in  : port granted in the previous round
//   valid_o       out : at least one port requests
//   winner_o      out : chosen port (a lone requester wins; on a tie the port
//                       that did not win last time)
// ---------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    valid_o  = |req_i;
    winner_o = PORT_I;
    if (req_i == 2'b11) begin
      winner_o = ~last_grant_i;
    end else if (req_i[PORT_D]) begin
      winner_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one line-wide memory port between the instruction cache (port 0)
// and the data cache (port 1). One line transaction at a time, round-robin
// on ties, optional timeout guard on the memory acknowledge.
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   pN_req/write/addr/data_i: requester N command, held until pN_ack_o
//   pN_data_o, pN_ack_o     : read data and 1-cycle completion for port N
//   mem_enable/write/addr/data_o, mem_data_i, mem_ack_i : memory handshake
//   grant_o                 : owning port while busy_o = 1
//   busy_o                  : a transaction is in flight
//   timeout_o               : sticky, set when memory failed to ack in time
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int              CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             TMO_EN   = (TIMEOUT != 0);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout;
  logic              w_arb_valid;
  logic              w_arb_winner;
  logic              w_tmo_hit;

  mem_arb_rr u_rr (
    .req_i        ({p1_req_i, p0_req_i}),
    .last_grant_i (r_last_grant),
    .valid_o      (w_arb_valid),
    .winner_o     (w_arb_winner)
  );

  // Next state and state-decoded outputs. Everything visible to the
  // requesters and memory comes from registers, so an asynchronous reset
  // drops mem_enable_o and the acks immediately.
  always_comb begin
    w_next_state = r_state;
    w_tmo_hit    = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    p0_ack_o     = 1'b0;
    p1_ack_o     = 1'b0;
    busy_o       = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid) w_next_state = BUSY;
      end
      BUSY: begin
        mem_enable_o = 1'b1;
        mem_write_o  = r_write;
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (mem_ack_i) begin
          w_next_state = RESP;
        end else if (TMO_EN && (r_cnt == CNT_LAST)) begin
          w_next_state = RESP;
          w_tmo_hit    = 1'b1;
        end
      end
      RESP: begin
        p0_ack_o     = (r_grant == PORT_I);
        p1_ack_o     = (r_grant == PORT_D);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= PORT_D;   // port 0 wins the first tie after reset
      r_grant      <= PORT_I;
      r_write      <= 1'b0;
      // NOTE: the wide line registers are reset on purpose: they drive the
      // memory and requester data pins directly, which must read zero after reset.
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // values from before this edge, independent of statement order.
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_arb_valid) begin
            r_grant      <= w_arb_winner;
            r_last_grant <= w_arb_winner;
            if (w_arb_winner == PORT_D) begin
              r_write <= p1_write_i;
              r_addr  <= p1_addr_i;
              r_wdata <= p1_data_i;
            end else begin
              r_write <= p0_write_i;
              r_addr  <= p0_addr_i;
              r_wdata <= p0_data_i;
            end
          end
        end
        BUSY: begin
          // Cannot wrap with the timeout enabled: BUSY is left at CNT_LAST.
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack_i) begin
            if (!r_write) r_rdata <= mem_data_i;
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_rdata   <= '0;
          end
        end
        RESP: r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign mem_addr_o = r_addr;
  assign mem_data_o = r_wdata;
  assign p0_data_o  = r_rdata;
  assign p1_data_o  = r_rdata;
  assign grant_o    = r_grant;
  assign timeout_o  = r_timeout;

endmodule
